ddr_native_app_model: RTL

- Synthesizable responder for the Xilinx DDR native app interface, the memory-controller side of the app_* handshake.
- Stands in for the MIG core in simulation and in loopback FPGA builds, so the native-interface FIFO front-end and the axi4-to-DDR path can be exercised without a PHY.
- Accepts commands and write data with optional pseudo-random backpressure, executes them in order against an internal RAM, and returns read data after a fixed latency.

---
 rtl/ddr_native_model_pkg.sv | 21 ++
 rtl/common_fifo.sv | 51 +++++
 rtl/ddr_native_app_model.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ddr_native_model_pkg.sv
// Shared types and constants for the DDR native app-interface responder model.
package ddr_native_model_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   // x^16+x^14+x^13+x^11 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam int unsigned CMD_IDX_W = 10;

   typedef struct packed {
      logic [2:0]           cmd;
      logic [CMD_IDX_W-1:0] idx;
   } cmd_entry_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/common_fifo.sv
// Small synchronous show-ahead FIFO; DEPTH must be a power of two.
module common_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ddr_native_app_model.sv
// Memory-controller side of the DDR native app interface: in-order command
// execution against an internal RAM, fixed read latency, optional backpressure.
module ddr_native_app_model
   import ddr_native_model_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 27,
   parameter int unsigned DATA_WIDTH   = 256,
   parameter int unsigned ADDR_LSB     = 3,
   parameter int unsigned MEM_AWIDTH   = CMD_IDX_W,
   parameter int unsigned CALIB_CYCLES = 16,
   parameter int unsigned RD_LATENCY   = 8,
   parameter bit          BP_EN        = 1'b1,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   app_addr,
   input  logic [2:0]              app_cmd,
   input  logic                    app_en,
   output logic                    app_rdy,
   input  logic [DATA_WIDTH-1:0]   app_wdf_data,
   input  logic                    app_wdf_end,
   input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                    app_wdf_wren,
   output logic                    app_wdf_rdy,
   output logic [DATA_WIDTH-1:0]   app_rd_data,
   output logic                    app_rd_data_valid,
   output logic                    app_rd_data_end,
   output logic                    init_calib_complete,
   output logic                    cmd_err,
   output logic [31:0]             wr_cnt,
   output logic [31:0]             rd_cnt
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned WDF_W  = DATA_WIDTH + NBYTES;
   localparam int unsigned CAL_W  = $clog2(CALIB_CYCLES + 1);

   logic [CAL_W-1:0]      cal_cnt;
   logic [15:0]           lfsr;
   cmd_entry_t            cmd_in;
   cmd_entry_t            cmd_head;
   logic                  cmd_full, cmd_empty, wdf_full, wdf_empty;
   logic [WDF_W-1:0]      wdf_in, wdf_head;
   logic [DATA_WIDTH-1:0] wdf_head_data;
   logic [NBYTES-1:0]     wdf_head_mask;
   logic                  exec_wr, exec_rd, exec_bad, cmd_pop;
   logic [MEM_AWIDTH-1:0] head_idx;

   logic [DATA_WIDTH-1:0] ram [2**MEM_AWIDTH];
   logic [DATA_WIDTH-1:0] ram_q;
   logic [DATA_WIDTH-1:0] dpipe [1:RD_LATENCY-1];
   logic [RD_LATENCY-1:0] vpipe;

   assign app_rdy     = init_calib_complete && !cmd_full && (!BP_EN || lfsr[0]);
   assign app_wdf_rdy = init_calib_complete && !wdf_full && (!BP_EN || lfsr[5]);

   assign cmd_in = '{cmd: app_cmd, idx: CMD_IDX_W'(app_addr[ADDR_LSB +: MEM_AWIDTH])};
   assign wdf_in = {app_wdf_data, app_wdf_mask};
   assign {wdf_head_data, wdf_head_mask} = wdf_head;
   assign head_idx = MEM_AWIDTH'(cmd_head.idx);

   common_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(4)) u_cmd_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (app_en && app_rdy),
      .wdata (cmd_in),
      .pop   (cmd_pop),
      .rdata (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   common_fifo #(.WIDTH(WDF_W), .DEPTH(4)) u_wdf_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (app_wdf_wren && app_wdf_rdy),
      .wdata (wdf_in),
      .pop   (exec_wr),
      .rdata (wdf_head),
      .full  (wdf_full),
      .empty (wdf_empty)
   );

   // A write at the head stalls the whole queue until its data beat is present
   always_comb begin
      exec_wr  = 1'b0;
      exec_rd  = 1'b0;
      exec_bad = 1'b0;
      if (!cmd_empty) begin
         unique case (cmd_head.cmd)
            CMD_WR:  exec_wr  = !wdf_empty;
            CMD_RD:  exec_rd  = 1'b1;
            default: exec_bad = 1'b1;
         endcase
      end
   end

   assign cmd_pop = exec_wr || exec_rd || exec_bad;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cal_cnt             <= '0;
         init_calib_complete <= 1'b0;
         lfsr                <= LFSR_SEED;
         cmd_err             <= 1'b0;
         wr_cnt              <= '0;
         rd_cnt              <= '0;
      end else begin
         if (!init_calib_complete) begin
            cal_cnt             <= cal_cnt + 1'b1;
            init_calib_complete <= (cal_cnt == CAL_W'(CALIB_CYCLES - 1));
         end else begin
            lfsr <= lfsr_next(lfsr);
         end
         if (exec_bad || (app_wdf_wren && !app_wdf_end) ||
             (!init_calib_complete && (app_en || app_wdf_wren)))
            cmd_err <= 1'b1;
         if (exec_wr) wr_cnt <= wr_cnt + 1'b1;
         if (exec_rd) rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // RAM contents survive reset; the read register is the first delay-line stage
   always_ff @(posedge clock) begin
      if (exec_wr) begin
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (!wdf_head_mask[b]) ram[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
         end
      end
      if (exec_rd) ram_q <= ram[head_idx];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
         for (int unsigned k = 1; k < RD_LATENCY; k++) dpipe[k] <= '0;
      end else begin
         vpipe    <= {vpipe[RD_LATENCY-2:0], exec_rd};
         dpipe[1] <= ram_q;
         for (int unsigned k = 2; k < RD_LATENCY; k++) dpipe[k] <= dpipe[k-1];
      end
   end

   assign app_rd_data       = dpipe[RD_LATENCY-1];
   assign app_rd_data_valid = vpipe[RD_LATENCY-1];
   assign app_rd_data_end   = vpipe[RD_LATENCY-1];

endmodule
